// File: rtl/image_pkg.sv
// Shared image geometry, address/count widths and the arbiter state type.
package image_pkg;

    localparam int WIDTH      = 32;
    localparam int HEIGHT     = 24;
    localparam int IMAGE_SIZE = WIDTH * HEIGHT;
    localparam int ADDR_W     = $clog2(IMAGE_SIZE);
    localparam int CNT_W      = $clog2(IMAGE_SIZE + 1);
    localparam int PIX_W      = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2
    } arb_state_t;

endpackage

// File: rtl/image_bram_arbiter.sv
// Single-port image BRAM arbiter between the frame loader (writes) and the output path (reads).
// Optional read-after-write guard in FILL: define IMAGE_ARB_RAW_GUARD_EN.
module image_bram_arbiter
    import image_pkg::*;
#(
    parameter int MAX_WR_BURST = 8
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    output logic              wr_gnt,

    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic [PIX_W-1:0]  rd_data,
    output logic              rd_valid,

    input  logic              frame_start,
    output logic              frame_ready,

    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [PIX_W-1:0]  bram_din,
    input  logic [PIX_W-1:0]  bram_dout
);

    localparam int                 BURST_W   = $clog2(MAX_WR_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_WR_BURST);
    localparam logic [CNT_W-1:0]   LAST_CNT  = CNT_W'(IMAGE_SIZE - 1);

    arb_state_t         state;
    logic [CNT_W-1:0]   wr_count;
    logic [BURST_W-1:0] burst_cnt;
    logic               raw_ok;
    logic               rd_waiting;
    logic               burst_full;

    // A read may only target pixels already written in the current frame.
`ifdef IMAGE_ARB_RAW_GUARD_EN
    assign raw_ok = CNT_W'(rd_addr) < wr_count;
`else
    assign raw_ok = 1'b1;
`endif

    assign rd_waiting = rd_req && raw_ok && (state == FILL);
    assign burst_full = (burst_cnt == BURST_MAX);

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        wr_gnt = 1'b0;
        rd_gnt = 1'b0;
        if (!frame_start) begin
            case (state)
                FILL: begin
                    if (wr_req && !(rd_waiting && burst_full)) begin
                        wr_gnt = 1'b1;
                    end else if (rd_waiting) begin
                        rd_gnt = 1'b1;
                    end
                end
                READY:   rd_gnt = rd_req;
                default: ;
            endcase
        end
    end

    assign bram_en   = wr_gnt || rd_gnt;
    assign bram_we   = wr_gnt;
    assign bram_addr = wr_gnt ? wr_addr : (rd_gnt ? rd_addr : '0);
    assign bram_din  = wr_gnt ? wr_data : '0;

    // BRAM output is only meaningful in the cycle after a read grant.
    assign rd_data   = rd_valid ? bram_dout : '0;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            wr_count    <= '0;
            burst_cnt   <= '0;
            frame_ready <= 1'b0;
            rd_valid    <= 1'b0;
        end else begin
            rd_valid <= rd_gnt;
            if (frame_start) begin
                state       <= FILL;
                wr_count    <= '0;
                burst_cnt   <= '0;
                frame_ready <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        burst_cnt   <= '0;
                        frame_ready <= 1'b0;
                    end
                    FILL: begin
                        if (wr_gnt) begin
                            wr_count <= wr_count + 1'b1;
                            if (wr_count == LAST_CNT) begin
                                state       <= READY;
                                frame_ready <= 1'b1;
                            end
                        end
                        // Count writes that overtake a waiting read; any read grant resets fairness.
                        if (rd_gnt || !rd_waiting) begin
                            burst_cnt <= '0;
                        end else if (wr_gnt && !burst_full) begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                    end
                    READY: begin
                        burst_cnt   <= '0;
                        frame_ready <= 1'b1;
                    end
                    default: begin
                        state       <= IDLE;
                        wr_count    <= '0;
                        burst_cnt   <= '0;
                        frame_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_image_bram_arbiter.sv
// Directed-plus-random bench for image_bram_arbiter against a frame-level reference model.
module tb_image_bram_arbiter;
    import image_pkg::*;

    localparam int MAX_B = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              wr_req = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [PIX_W-1:0]  wr_data = '0;
    logic              wr_gnt;
    logic              rd_req = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              rd_gnt;
    logic [PIX_W-1:0]  rd_data;
    logic              rd_valid;
    logic              frame_start = 1'b0;
    logic              frame_ready;
    logic              bram_en;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [PIX_W-1:0]  bram_din;
    logic [PIX_W-1:0]  bram_dout;

    image_bram_arbiter #(.MAX_WR_BURST(MAX_B)) dut (
        .clock(clock), .reset(reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_data(rd_data), .rd_valid(rd_valid),
        .frame_start(frame_start), .frame_ready(frame_ready),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
        .bram_dout(bram_dout)
    );

    always #5 clock = ~clock;

    // Behavioural single-port BRAM, one-cycle read latency.
    logic [PIX_W-1:0] mem [IMAGE_SIZE];
    always @(posedge clock) begin
        if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_din;
            else         bram_dout      <= mem[bram_addr];
        end
    end

    int vectors = 0;
    int miscompares = 0;

    // Reference model: frame phase, pixels written, writes that overtook a waiting read.
    int               m_phase;   // 0 idle, 1 filling, 2 frame complete
    int               m_count;
    int               m_streak;
    logic             m_vld;
    logic [PIX_W-1:0] m_rdata;
    logic [PIX_W-1:0] shadow [IMAGE_SIZE];
    logic [PIX_W-1:0] seed;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic read_allowed(input int addr);
`ifdef IMAGE_ARB_RAW_GUARD_EN
        return addr < m_count;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [PIX_W-1:0] pix(input int addr);
        return PIX_W'(addr * 37) ^ seed;
    endfunction

    // One clock cycle: drive, check against the model, advance the model past the edge.
    task automatic step(input logic fs, input logic wr, input int wa, input logic rr, input int ra,
                        output logic gw, output logic gr);
        logic elig;
        frame_start = fs;
        wr_req      = wr;
        wr_addr     = ADDR_W'(wa);
        wr_data     = pix(wa);
        rd_req      = rr;
        rd_addr     = ADDR_W'(ra);
        #1;
        gw = 1'b0; gr = 1'b0; elig = 1'b0;
        if (!fs) begin
            if (m_phase == 2) begin
                gr = rr;
            end else if (m_phase == 1) begin
                elig = rr && read_allowed(ra);
                if (wr && !(elig && m_streak >= MAX_B)) gw = 1'b1;
                else if (elig)                          gr = 1'b1;
            end
        end
        check("wr_gnt", 32'(wr_gnt), 32'(gw));
        check("rd_gnt", 32'(rd_gnt), 32'(gr));
        check("bram_en", 32'(bram_en), 32'(gw | gr));
        check("bram_we", 32'(bram_we), 32'(gw));
        check("bram_addr", 32'(bram_addr), gw ? 32'(wa) : (gr ? 32'(ra) : 32'd0));
        check("bram_din", 32'(bram_din), gw ? 32'(pix(wa)) : 32'd0);
        check("rd_valid", 32'(rd_valid), 32'(m_vld));
        check("rd_data", 32'(rd_data), m_vld ? 32'(m_rdata) : 32'd0);
        check("frame_ready", 32'(frame_ready), 32'(m_phase == 2));
        @(posedge clock);
        m_vld   = gr;
        m_rdata = gr ? shadow[ra] : '0;
        if (fs) begin
            m_phase = 1; m_count = 0; m_streak = 0;
        end else if (m_phase == 1) begin
            if (gw) begin
                shadow[wa] = pix(wa);
                m_count++;
            end
            if (!elig || gr) m_streak = 0;
            else if (gw)     m_streak = (m_streak < MAX_B) ? m_streak + 1 : MAX_B;
            if (m_count == IMAGE_SIZE) m_phase = 2;
        end
        @(negedge clock);
    endtask

    task automatic apply_reset(input string tag);
        reset = 1'b0; wr_req = 1'b1; rd_req = 1'b1; frame_start = 1'b0;
        #1;
        m_phase = 0; m_count = 0; m_streak = 0; m_vld = 1'b0; m_rdata = '0;
        check({tag, "_wr_gnt"}, 32'(wr_gnt), 0);
        check({tag, "_rd_gnt"}, 32'(rd_gnt), 0);
        check({tag, "_bram_en"}, 32'(bram_en), 0);
        check({tag, "_rd_valid"}, 32'(rd_valid), 0);
        check({tag, "_rd_data"}, 32'(rd_data), 0);
        check({tag, "_frame_ready"}, 32'(frame_ready), 0);
        @(posedge clock);
        @(negedge clock);
        check({tag, "_edge_rd_valid"}, 32'(rd_valid), 0);
        check({tag, "_edge_wr_gnt"}, 32'(wr_gnt), 0);
        reset = 1'b1;
    endtask

    initial begin
        logic gw, gr;
        int   idx, rd_pend_addr, budget, reads;
        logic rd_pend;

        foreach (mem[i])    mem[i] = '0;
        foreach (shadow[i]) shadow[i] = '0;
        seed = PIX_W'($urandom);
        @(negedge clock);
        apply_reset("por");

        // IDLE: random requests never granted.
        for (int i = 0; i < 8; i++)
            step(0, 1'($urandom), $urandom_range(0, IMAGE_SIZE - 1), 1'($urandom),
                 $urandom_range(0, IMAGE_SIZE - 1), gw, gr);

        // Fill 100 pixels with random reads, then reset mid-frame.
        step(1, 1, 0, 1, 0, gw, gr);
        idx = 0;
        for (int i = 0; i < 200 && idx < 100; i++) begin
            step(0, 1, idx, 1'($urandom_range(0, 3) == 0), $urandom_range(0, IMAGE_SIZE - 1), gw, gr);
            if (gw) idx++;
        end
        check("count_before_reset", 32'(m_count), 32'd100);
        apply_reset("mid_fill");

        // New frame.
        seed = PIX_W'($urandom);
        step(1, 1, 0, 1, 0, gw, gr);
        idx = 0;
`ifndef IMAGE_ARB_RAW_GUARD_EN
        // Unguarded: any address is readable while filling.
        step(0, 0, 0, 1, 500, gw, gr);
        check("unguarded_rd_gnt", 32'(gr), 32'd1);
`endif
        for (int i = 0; i < 10; i++) begin
            step(0, 1, idx, 0, 0, gw, gr);
            if (gw) idx++;
        end
`ifdef IMAGE_ARB_RAW_GUARD_EN
        // Read of an unwritten pixel waits until it is written, then 4 more writes overtake it.
        for (int i = 0; i < 40; i++) begin
            step(0, 1, idx, 1, 20, gw, gr);
            if (gw) idx++;
            if (gr) break;
        end
        check("raw_read_after_writes", 32'(idx), 32'd25);
`endif

        // Continuous writes against an always-eligible read: W,W,W,W,R.
        reads = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 1, idx, 1, 0, gw, gr);
            if (gw) idx++;
            if (gr) reads++;
        end
        check("burst_reads_in_20", 32'(reads), 32'd4);

        // Finish the frame with random requesters that hold until granted.
        rd_pend = 1'b0; rd_pend_addr = 0;
        budget = 0;
        while (m_phase == 1 && budget < 4000) begin
            if (!rd_pend && $urandom_range(0, 2) == 0) begin
                rd_pend = 1'b1;
                rd_pend_addr = $urandom_range(0, IMAGE_SIZE - 1);
            end
            step(0, ($urandom_range(0, 9) != 0), idx, rd_pend, rd_pend_addr, gw, gr);
            if (gw) idx++;
            if (gr) rd_pend = 1'b0;
            budget++;
        end
        check("frame_complete", 32'(m_phase), 32'd2);

        // READY: writes refused, reads every cycle.
        for (int i = 0; i < 10; i++) step(0, 1, 3, 1, 5, gw, gr);
        for (int i = 0; i < 30; i++)
            step(0, 1'($urandom), 0, 1'($urandom), $urandom_range(0, IMAGE_SIZE - 1), gw, gr);

        // frame_start wins over pending requests, in READY and mid-FILL.
        seed = PIX_W'($urandom);
        step(1, 1, 0, 1, 5, gw, gr);
        idx = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 1, idx, 1'($urandom), $urandom_range(0, 15), gw, gr);
            if (gw) idx++;
        end
        step(1, 1, idx, 1, 0, gw, gr);
        idx = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 1, idx, 1'($urandom), $urandom_range(0, 15), gw, gr);
            if (gw) idx++;
        end
        check("restart_count", 32'(m_count), 32'(idx));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
